// File: rtl/multiplier_pkg.sv
// Shared multiplier definitions: FSM state encoding and default width/latency,
// so datapath control and verification agree on one cycle count.
package multiplier_pkg;

    localparam int MUL_WIDTH   = 32;
    localparam int MUL_LATENCY = MUL_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

endpackage

// File: rtl/multiplier.sv
// Iterative shift-add signed/unsigned multiplier, WIDTH+1 cycles from start to done.
// No backpressure: a new start always aborts any multiply in flight and restarts.
module multiplier
    import multiplier_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 a_signed,
    input  logic                 b_signed,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH);

    mult_state_t          r_state;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_p;
    logic [2*WIDTH-1:0]   r_product;
    logic [WIDTH-1:0]     r_amag;
    logic                 r_neg;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [WIDTH:0]       w_sum;

    // Most negative operand negates to itself, which is exactly its unsigned magnitude.
    always_comb begin
        w_a_neg = a_signed & a[WIDTH-1];
        w_b_neg = b_signed & b[WIDTH-1];
        w_a_mag = w_a_neg ? -a : a;
        w_b_mag = w_b_neg ? -b : b;
        w_sum   = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_amag} : '0);
    end

    always_ff @(posedge clk) begin
        if (start) begin
            r_amag <= w_a_mag;
            r_neg  <= w_a_neg ^ w_b_neg;
            r_p    <= {{WIDTH{1'b0}}, w_b_mag};
        end else if (r_state == RUN) begin
            r_p    <= {w_sum, r_p[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_product <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (start) begin
            r_state   <= RUN;
            r_cnt     <= CW'(WIDTH - 1);
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == '0) r_state <= FIX;
                end
                FIX: begin
                    r_product <= r_neg ? -r_p : r_p;
                    r_state   <= DONE;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_multiplier.sv
// Randomized scoreboard bench for multiplier: expectations queued at start, checked on done.
module tb_multiplier;
    import multiplier_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [2*W-1:0] prod;
        int             t0;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [W-1:0]     a = '0;
    logic [W-1:0]     b = '0;
    logic             a_signed = 1'b0;
    logic             b_signed = 1'b0;
    logic [2*W-1:0]   product;
    logic             busy;
    logic             done;

    int               checks = 0;
    int               failures = 0;
    int               cyc = 0;
    exp_t             q[$];
    logic [2*W-1:0]   held = '0;
    logic             prev_done = 1'b0;

    multiplier #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .a_signed(a_signed), .b_signed(b_signed),
        .product(product), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    // Reference: extend each operand to its true integer value and multiply.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input bit xs, input bit ys);
        longint vx, vy;
        vx = xs ? longint'($signed(x)) : longint'({32'd0, x});
        vy = ys ? longint'($signed(y)) : longint'({32'd0, y});
        return 64'(vx * vy);
    endfunction

    // Monitor: on done rising pop and compare; otherwise product must hold its last result.
    always @(negedge clk) begin
        if (reset) begin
            held      = '0;
            prev_done = 1'b0;
        end else begin
            if (done && !prev_done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("product", product, e.prod);
                    check("latency", 64'(cyc - e.t0), 64'(MUL_LATENCY));
                    check("busy_at_done", 64'(busy), 0);
                    held = e.prod;
                end
            end else begin
                check("product_hold", product, held);
            end
            prev_done = done;
        end
    end

    task automatic scramble();
        a        = $urandom;
        b        = $urandom;
        a_signed = 1'($urandom);
        b_signed = 1'($urandom);
    endtask

    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit as, input bit bs);
        exp_t e;
        @(negedge clk);
        if (busy && q.size() > 0) void'(q.pop_back());
        e.prod = ref_mul(av, bv, as, bs);
        e.t0   = cyc + 1;
        q.push_back(e);
        a = av; b = bv; a_signed = as; b_signed = bs;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_ack", {62'd0, busy, done}, 64'd2);
        scramble();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            scramble();
            n++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 reset = 1'b1;
        #1;
        check("reset_product", product, 0);
        check("reset_busy_done", {62'd0, busy, done}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        issue(32'd7, 32'd6, 0, 0);                 wait_done();
        issue(32'hFFFF_FFFD, 32'd5, 1, 1);         wait_done();
        check("neg15", product, 64'hFFFF_FFFF_FFFF_FFF1);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0); wait_done();
        check("umax_sq", product, 64'hFFFF_FFFE_0000_0001);
        issue(32'h8000_0000, 32'h8000_0000, 1, 1); wait_done();
        check("smin_sq", product, 64'h4000_0000_0000_0000);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0); wait_done();
        check("mulhsu", product, 64'hFFFF_FFFF_0000_0001);
        issue(32'd0, 32'h8000_0000, 1, 1);         wait_done();
        check("zero_neg", product, 0);

        issue(32'd3, 32'd4, 0, 0);                 wait_done();
        issue(32'd5, 32'd5, 0, 0);
        repeat (8) @(negedge clk);
        issue(32'd9, 32'd9, 0, 0);                 wait_done();
        check("restart81", product, 64'd81);

        issue(32'd7, 32'd6, 0, 0);
        repeat (14) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_product", product, 0);
        check("arst_busy_done", {62'd0, busy, done}, 0);
        q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        issue(32'd2, 32'd3, 0, 0);                 wait_done();
        check("after_reset", product, 64'd6);

        for (int i = 0; i < 40; i++) begin
            issue(pick(), pick(), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                issue(pick(), pick(), 1'($urandom), 1'($urandom));
            end
            wait_done();
        end

        @(negedge clk);
        if (q.size() != 0) check("queue_drained", 64'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multiplier.md
Name: multiplier

Overview:
- Iterative shift-add multiplier; the multiply counterpart of the datapath's sequential divider.
- Accepts operands `a`, `b` and produces the full double-width product over a fixed number of cycles.
- Each operand can independently be treated as signed (two's complement) or unsigned, so it covers MUL/MULH/MULHSU/MULHU-style requests.
- Sits in the datapath beside the divider; uses the same start/done convention.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH. Legal values: power of two, at least 4.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle pulse; latches operands and begins a multiply
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- a_signed  input  1  1 = `a` is two's complement; 0 = unsigned
- b_signed  input  1  1 = `b` is two's complement; 0 = unsigned
- product  output  2*WIDTH  result of the last completed multiply
- busy  output  1  high while a multiply is in progress
- done  output  1  high from completion until the next start

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high.
- Reset values: product=0, busy=0, done=0, state=IDLE. Internal registers need no reset beyond the state and counter.
- States: IDLE, RUN, FIX, DONE. `busy` = (state==RUN || state==FIX). `done` = (state==DONE).
- start, sampled in any state: on the edge where start=1, the block latches the following.
  - a_mag = |a| when a_signed and a[WIDTH-1]=1, otherwise `a`. Same rule gives b_mag from `b` and b_signed.
  - neg = (a_signed & a[MSB]) XOR (b_signed & b[MSB]).
  - Working register p[2*WIDTH-1:0] = {0, b_mag}.
  - counter = WIDTH-1; state goes to RUN.
- Magnitude of the most negative value (e.g. 0x8000_0000) is 2^(WIDTH-1) and fits unsigned in WIDTH bits. No overflow path.
- RUN, one step per cycle:
  - sum[WIDTH:0] = p[2W-1:W] + (p[0] ? a_mag : 0).
  - p <= {sum, p[W-1:1]}, i.e. a right shift that keeps the carry.
  - counter decrements. When counter==0 on this edge, next state is FIX.
- FIX: product <= neg ? (~p + 1) : p, computed modulo 2^(2W). State goes to DONE.
- DONE: product and done hold until the next start. Both operands zero, or one zero, gives product 0 regardless of the neg flag.
- Latency: start sampled at edge 0 gives WIDTH RUN edges (1..WIDTH), then the FIX edge at WIDTH+1. done and the new product are visible after edge WIDTH+1, i.e. 33 cycles for WIDTH=32.
- `product` output:
  - Separate from `p`; holds the previous result throughout RUN/FIX.
  - Changes only on the FIX edge or on reset.
- start while busy: aborts the current operation, no product update, restarts with the new operands. Latency is counted from the new start.
- start while done: done drops on the next edge and busy rises. `product` keeps the old value until the new FIX.
- Operand inputs are only sampled on the start edge; changes during RUN have no effect.
- reset mid-operation: immediately returns to IDLE, product=0, done=0, busy=0.
- start and reset asserted together: reset wins.

Decomposition:
- Shared datapath package holds:
  - mult_state_t, the enum {IDLE, RUN, FIX, DONE};
  - MUL_LATENCY = WIDTH+1, so the pipeline control and the bench use one constant.
- No sub-module is natural. The magnitude/negate logic and the add-shift step are a few lines of always_comb inside the block.

Test Plan:
- Unsigned small: a=7, b=6, unsigned. Expect busy=1 for 33 cycles, then done=1, product=42; busy=0 from the same cycle.
- Signed mixed sign: a=0xFFFF_FFFD (-3), b=5, both signed. Expect product=0xFFFF_FFFF_FFFF_FFF1 (-15).
- Extremes:
  - a=b=0xFFFF_FFFF unsigned: expect product=0xFFFF_FFFE_0000_0001.
  - a=b=0x8000_0000 both signed: expect product=0x4000_0000_0000_0000.
- MULHSU-style: a=0xFFFF_FFFF signed (-1), b=0xFFFF_FFFF unsigned. Expect product=0xFFFF_FFFF_0000_0001. Also a=0, b=0x8000_0000 signed: expect product=0.
- Restart/hold: start 3*4, complete with product=12. Issue start 5*5, then at cycle 10 issue start 9*9.
  - product must stay 12 until the final completion.
  - done must rise exactly 33 cycles after the 9*9 start, with product=81.
- Reset mid-op: assert reset at cycle 15 of a 7*6 multiply. Expect product=0, done=0, busy=0 immediately (asynchronous). A subsequent start 2*3 yields 6 after 33 cycles.
